// File: rtl/k6502_bus_resp.sv
// k6502 CPU bus responder: RAM plus a 16-byte I/O page holding a console FIFO,
// a sticky halt/exit-code register and cycle / instruction counters.
module k6502_bus_resp #(
    parameter int          RAM_AW     = 11,
    parameter logic [15:0] RAM_BASE   = 16'h0000,
    parameter logic [15:0] IO_BASE    = 16'hF000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic        rw,
    input  logic        sync,
    input  logic [7:0]  d_in,
    output logic [7:0]  d_out,
    output logic        d_oe,
    output logic [7:0]  con_data,
    output logic        con_valid,
    input  logic        con_ready,
    output logic        halt,
    output logic [7:0]  halt_code
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [3:0] OFF_CON   = 4'd0;
    localparam logic [3:0] OFF_HALT  = 4'd1;
    localparam logic [3:0] OFF_CYC_L = 4'd2;
    localparam logic [3:0] OFF_CYC_H = 4'd3;
    localparam logic [3:0] OFF_INSN  = 4'd4;

    logic [7:0] ram_mem  [2**RAM_AW];
    logic [7:0] fifo_mem [FIFO_DEPTH];

    logic [7:0]    d_out_q, d_out_d;
    logic          d_oe_q, d_oe_d;
    logic          halt_q, halt_d;
    logic [7:0]    halt_code_q, halt_code_d;
    logic [15:0]   cyc_q, cyc_d;
    logic [15:0]   icnt_q, icnt_d;
    logic [7:0]    cyc_hi_snap_q, cyc_hi_snap_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]    count_q, count_d;
    logic          ovf_q, ovf_d;

    logic       ram_sel, io_hit, io_wr, io_rd, ram_we;
    logic [3:0] io_off;
    logic       con_push, con_pop, fifo_full, push_ok, fifo_we;
    logic       halt_wr, insn_wr;
    logic [7:0] io_rdata;

    // NOTE: combinational logic uses blocking '=' with a default first so no
    // latch can be inferred; every flop below is updated with non-blocking '<='.
    always_comb begin
        ram_sel  = a[15:RAM_AW] == RAM_BASE[15:RAM_AW];
        io_hit   = (a[15:4] == IO_BASE[15:4]) && !ram_sel;
        io_off   = a[3:0];
        io_wr    = io_hit && !rw;
        io_rd    = io_hit && rw;
        ram_we   = ram_sel && !rw && !rst;

        con_push  = io_wr && (io_off == OFF_CON);
        halt_wr   = io_wr && (io_off == OFF_HALT);
        insn_wr   = io_wr && (io_off == OFF_INSN);
        con_pop   = (count_q != 5'd0) && con_ready;
        fifo_full = count_q == 5'(FIFO_DEPTH);
        push_ok   = con_push && (!fifo_full || con_pop);
        fifo_we   = push_ok && !rst;

        case (io_off)
            OFF_CON:   io_rdata = {ovf_q, 2'b00, count_q};
            OFF_HALT:  io_rdata = halt_code_q;
            OFF_CYC_L: io_rdata = cyc_q[7:0];
            OFF_CYC_H: io_rdata = cyc_hi_snap_q;
            OFF_INSN:  io_rdata = icnt_q[7:0];
            default:   io_rdata = 8'h00;
        endcase

        d_out_d = d_out_q;
        d_oe_d  = 1'b0;
        if (rw) begin
            if (ram_sel) begin
                d_out_d = ram_mem[a[RAM_AW-1:0]];
                d_oe_d  = 1'b1;
            end else if (io_hit) begin
                d_out_d = io_rdata;
                d_oe_d  = 1'b1;
            end else begin
                d_out_d = 8'hFF;
            end
        end

        halt_d      = halt_q | halt_wr;
        halt_code_d = (halt_wr && !halt_q) ? d_in : halt_code_q;

        cyc_d = halt_q ? cyc_q : cyc_q + 16'd1;
        if (insn_wr)
            icnt_d = 16'd0;
        else if (sync && !halt_q)
            icnt_d = icnt_q + 16'd1;
        else
            icnt_d = icnt_q;

        cyc_hi_snap_d = (io_rd && (io_off == OFF_CYC_L)) ? cyc_q[15:8] : cyc_hi_snap_q;

        wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = con_pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + {4'b0, push_ok} - {4'b0, con_pop};
        ovf_d    = ovf_q | (con_push && fifo_full && !con_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_out_q       <= 8'h00;
            d_oe_q        <= 1'b0;
            halt_q        <= 1'b0;
            halt_code_q   <= 8'h00;
            cyc_q         <= 16'h0000;
            icnt_q        <= 16'h0000;
            cyc_hi_snap_q <= 8'h00;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= 5'd0;
            ovf_q         <= 1'b0;
        end else begin
            d_out_q       <= d_out_d;
            d_oe_q        <= d_oe_d;
            halt_q        <= halt_d;
            halt_code_q   <= halt_code_d;
            cyc_q         <= cyc_d;
            icnt_q        <= icnt_d;
            cyc_hi_snap_q <= cyc_hi_snap_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            ovf_q         <= ovf_d;
        end
    end

    // NOTE: storage arrays carry no reset so they map onto block RAM; the
    // pointers and count above define which FIFO entries are meaningful.
    always_ff @(posedge clk) begin
        if (ram_we)
            ram_mem[a[RAM_AW-1:0]] <= d_in;
        if (fifo_we)
            fifo_mem[wr_ptr_q] <= d_in;
    end

    assign d_out     = d_out_q;
    assign d_oe      = d_oe_q;
    assign halt      = halt_q;
    assign halt_code = halt_code_q;
    assign con_valid = count_q != 5'd0;
    assign con_data  = fifo_mem[rd_ptr_q];

endmodule
